// File: rtl/alu_issue_unit.sv
// rtl/alu_issue_unit.sv - operand issue and writeback stage in front of the 8-bit ALU
module alu_issue_unit #(
  parameter int DW = 8,
  parameter int AW = 3,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [CW-1:0] in_op,
  input  logic [AW-1:0] in_rd,
  input  logic [AW-1:0] in_rs,
  input  logic [AW-1:0] in_rt,
  output logic [CW-1:0] alu_ctrl,
  output logic [DW-1:0] alu_x,
  output logic [DW-1:0] alu_y,
  input  logic          alu_carry,
  input  logic [DW-1:0] alu_out,
  output logic          carry_flag,
  output logic          done,
  input  logic          pl_we,
  input  logic [AW-1:0] pl_addr,
  input  logic [DW-1:0] pl_data,
  input  logic [AW-1:0] dbg_addr,
  output logic [DW-1:0] dbg_data
);

  localparam int NREG = 1 << AW;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] op_q;
  logic [AW-1:0] rd_q, rs_q, rt_q;
  logic [DW-1:0] rf_q [NREG];
  logic          carry_q;
  logic [CW-1:0] ctrl_hold_q;
  logic [DW-1:0] x_hold_q, y_hold_q;
  logic          accept, exec, wb_en;

  assign accept = in_ready & in_valid;
  assign exec   = (state_q == EXEC);
  assign wb_en  = exec && (rd_q != '0);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state and handshake outputs: one accept, one ALU cycle, one done cycle
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    done     = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = EXEC;
      end
      EXEC:    state_d = DONE;
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Latch the command fields on the accept handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q <= '0;
      rd_q <= '0;
      rs_q <= '0;
      rt_q <= '0;
    end else if (accept) begin
      op_q <= in_op;
      rd_q <= in_rd;
      rs_q <= in_rs;
      rt_q <= in_rt;
    end
  end

  // ALU drive: live register read in EXEC (file as of entering EXEC), held value otherwise
  always_comb begin
    alu_ctrl = ctrl_hold_q;
    alu_x    = x_hold_q;
    alu_y    = y_hold_q;
    if (exec) begin
      alu_ctrl = op_q;
      alu_x    = rf_q[rs_q];
      alu_y    = rf_q[rt_q];
    end
  end

  // Capture what was driven during EXEC so the ALU inputs stay stable afterwards
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_hold_q <= '0;
      x_hold_q    <= '0;
      y_hold_q    <= '0;
    end else if (exec) begin
      ctrl_hold_q <= alu_ctrl;
      x_hold_q    <= alu_x;
      y_hold_q    <= alu_y;
    end
  end

  // Register file: preload first, writeback assigned last so it wins a same-register collision
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else begin
      if (pl_we && (pl_addr != '0)) rf_q[pl_addr] <= pl_data;
      if (wb_en)                    rf_q[rd_q]    <= alu_out;
    end
  end

  // Carry is captured on every completed command, including ones targeting r0
  always_ff @(posedge clk) begin
    if (rst)       carry_q <= 1'b0;
    else if (exec) carry_q <= alu_carry;
  end

  assign carry_flag = carry_q;
  assign dbg_data   = rf_q[dbg_addr];

endmodule

// File: tb/tb_alu_issue_unit.sv
// tb/tb_alu_issue_unit.sv - self-checking bench for alu_issue_unit
module tb_alu_issue_unit;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_op;
  logic [2:0] in_rd, in_rs, in_rt;
  logic [3:0] alu_ctrl;
  logic [7:0] alu_x, alu_y;
  logic       alu_carry;
  logic [7:0] alu_out;
  logic       carry_flag;
  logic       done;
  logic       pl_we;
  logic [2:0] pl_addr;
  logic [7:0] pl_data;
  logic [2:0] dbg_addr;
  logic [7:0] dbg_data;

  int total = 0;
  int bad   = 0;

  alu_issue_unit #(.DW(8), .AW(3), .CW(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rs(in_rs), .in_rt(in_rt),
    .alu_ctrl(alu_ctrl), .alu_x(alu_x), .alu_y(alu_y),
    .alu_carry(alu_carry), .alu_out(alu_out),
    .carry_flag(carry_flag), .done(done),
    .pl_we(pl_we), .pl_addr(pl_addr), .pl_data(pl_data),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  // Stand-in ALU: {carry, out}
  function automatic logic [8:0] alu_fn(input logic [3:0] c, input logic [7:0] x, input logic [7:0] y);
    case (c)
      4'd0:    alu_fn = {1'b0, x} + {1'b0, y};
      4'd1:    alu_fn = {x < y, x - y};
      4'd2:    alu_fn = {1'b0, x & y};
      4'd3:    alu_fn = {1'b0, x | y};
      4'd4:    alu_fn = {1'b1, ~x};
      default: alu_fn = {x[7], y};
    endcase
  endfunction

  always_comb {alu_carry, alu_out} = alu_fn(alu_ctrl, alu_x, alu_y);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic dbg(input logic [2:0] a, output logic [7:0] d);
    dbg_addr = a;
    #1;
    d = dbg_data;
  endtask

  task automatic pl(input logic [2:0] a, input logic [7:0] d);
    pl_we = 1'b1; pl_addr = a; pl_data = d;
    tick();
    pl_we = 1'b0;
  endtask

  task automatic issue(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs, input logic [2:0] rt);
    in_valid = 1'b1; in_op = op; in_rd = rd; in_rs = rs; in_rt = rt;
    chk("issue_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; pl_we = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  typedef struct {
    logic [3:0] op;
    logic [2:0] rd, rs, rt;
    logic [7:0] xv, yv, eout;
    logic       ec;
  } vec_t;

  vec_t tbl[7];

  logic [7:0] m [8];
  logic       mc;

  task automatic mwrite(input logic [2:0] a, input logic [7:0] d);
    if (a != 3'd0) m[a] = d;
  endtask

  task automatic rand_pl();
    pl_we   = $urandom_range(0, 1);
    pl_addr = 3'($urandom_range(0, 7));
    pl_data = 8'($urandom);
    if (pl_we) mwrite(pl_addr, pl_data);
  endtask

  initial begin
    #10000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] d;
    int lows, n;
    logic [3:0] op;
    logic [2:0] rd, rs, rt, a;
    logic [7:0] ex, ey;
    logic [8:0] res;

    tbl[0] = '{op:4'd0, rd:3'd3, rs:3'd1, rt:3'd2, xv:8'h80, yv:8'h90, eout:8'h10, ec:1'b1};
    tbl[1] = '{op:4'd1, rd:3'd5, rs:3'd6, rt:3'd7, xv:8'h05, yv:8'h07, eout:8'hFE, ec:1'b1};
    tbl[2] = '{op:4'd2, rd:3'd7, rs:3'd2, rt:3'd3, xv:8'hF0, yv:8'h3C, eout:8'h30, ec:1'b0};
    tbl[3] = '{op:4'd3, rd:3'd1, rs:3'd4, rt:3'd5, xv:8'hF0, yv:8'h0C, eout:8'hFC, ec:1'b0};
    tbl[4] = '{op:4'd4, rd:3'd2, rs:3'd6, rt:3'd1, xv:8'h0F, yv:8'h99, eout:8'hF0, ec:1'b1};
    tbl[5] = '{op:4'd9, rd:3'd6, rs:3'd3, rt:3'd4, xv:8'h80, yv:8'h5A, eout:8'h5A, ec:1'b1};
    tbl[6] = '{op:4'd0, rd:3'd4, rs:3'd4, rt:3'd5, xv:8'h01, yv:8'h01, eout:8'h02, ec:1'b0};

    in_valid = 0; in_op = 0; in_rd = 0; in_rs = 0; in_rt = 0;
    pl_we = 0; pl_addr = 0; pl_data = 0; dbg_addr = 0;

    // reset state
    do_reset();
    chk("rst_ready", in_ready, 1);
    chk("rst_done", done, 0);
    chk("rst_carry", carry_flag, 0);
    chk("rst_alu_x", alu_x, 0);
    chk("rst_alu_ctrl", alu_ctrl, 0);
    for (int i = 0; i < 8; i++) begin
      dbg(3'(i), d);
      chk("rst_reg", d, 0);
    end

    // table-driven vectors
    foreach (tbl[i]) begin
      pl(tbl[i].rs, tbl[i].xv);
      pl(tbl[i].rt, tbl[i].yv);
      issue(tbl[i].op, tbl[i].rd, tbl[i].rs, tbl[i].rt);
      chk("vec_ctrl", alu_ctrl, tbl[i].op);
      chk("vec_x", alu_x, tbl[i].xv);
      chk("vec_y", alu_y, tbl[i].yv);
      chk("vec_exec_done", done, 0);
      tick();
      chk("vec_done", done, 1);
      dbg(tbl[i].rd, d);
      chk("vec_result", d, tbl[i].eout);
      chk("vec_carry", carry_flag, tbl[i].ec);
      tick();
      chk("vec_done_clear", done, 0);
    end

    // NOT through stand-in ALU
    pl(3'd1, 8'h00);
    issue(4'b0100, 3'd2, 3'd1, 3'd0);
    chk("not_x", alu_x, 8'h00);
    chk("not_ctrl", alu_ctrl, 4'b0100);
    chk("not_done_early", done, 0);
    tick();
    chk("not_done", done, 1);
    dbg(3'd2, d);
    chk("not_r2", d, 8'hFF);
    tick();
    chk("not_done_once", done, 0);
    chk("not_ready_back", in_ready, 1);

    // back-to-back with dependency
    pl(3'd1, 8'h11);
    pl(3'd2, 8'h22);
    in_valid = 1; in_op = 4'd0; in_rd = 3'd3; in_rs = 3'd1; in_rt = 3'd2;
    chk("b2b_ready_a", in_ready, 1);
    tick();
    in_op = 4'd2; in_rd = 3'd4; in_rs = 3'd3; in_rt = 3'd1;
    lows = 0; n = 0;
    while (in_ready !== 1'b1 && n < 10) begin
      lows++; n++;
      tick();
    end
    chk("b2b_gap", lows, 2);
    tick();
    in_valid = 0;
    chk("b2b_ctrl", alu_ctrl, 4'd2);
    chk("b2b_x", alu_x, 8'h33);
    tick();
    chk("b2b_done", done, 1);
    dbg(3'd4, d);
    chk("b2b_r4", d, 8'h11);
    chk("b2b_carry", carry_flag, 0);
    tick();

    // r0 protection
    pl(3'd1, 8'h00);
    pl(3'd0, 8'h55);
    dbg(3'd0, d);
    chk("r0_pl", d, 8'h00);
    in_valid = 1; in_op = 4'b0100; in_rd = 3'd0; in_rs = 3'd1; in_rt = 3'd0;
    pl_we = 1; pl_addr = 3'd0; pl_data = 8'h55;
    chk("r0_ready", in_ready, 1);
    tick();
    in_valid = 0; pl_we = 0;
    dbg(3'd0, d);
    chk("r0_exec", d, 8'h00);
    chk("r0_x", alu_x, 8'h00);
    tick();
    dbg(3'd0, d);
    chk("r0_after", d, 8'h00);
    chk("r0_carry", carry_flag, 1);
    chk("r0_done", done, 1);
    tick();

    // writeback/preload collision
    pl(3'd1, 8'h0F);
    issue(4'b0100, 3'd3, 3'd1, 3'd0);
    pl_we = 1; pl_addr = 3'd3; pl_data = 8'hAA;
    tick();
    pl_we = 0;
    dbg(3'd3, d);
    chk("coll_r3", d, 8'hF0);
    tick();

    // reset during EXEC
    pl(3'd5, 8'h3C);
    issue(4'b0100, 3'd6, 3'd5, 3'd0);
    chk("rmid_x", alu_x, 8'h3C);
    rst = 1;
    tick();
    rst = 0;
    chk("rmid_ready", in_ready, 1);
    chk("rmid_done", done, 0);
    chk("rmid_carry", carry_flag, 0);
    chk("rmid_alu_x", alu_x, 0);
    dbg(3'd6, d);
    chk("rmid_r6", d, 8'h00);
    tick();
    chk("rmid_done_later", done, 0);
    dbg(3'd6, d);
    chk("rmid_r6_later", d, 8'h00);

    // randomized run against a transaction-level model
    do_reset();
    for (int i = 0; i < 8; i++) m[i] = 8'h00;
    mc = 1'b0;
    for (int t = 0; t < 200; t++) begin
      n = $urandom_range(0, 2);
      for (int g = 0; g < n; g++) begin
        chk("rnd_idle_ready", in_ready, 1);
        rand_pl();
        tick();
      end
      op = 4'($urandom); rd = 3'($urandom); rs = 3'($urandom); rt = 3'($urandom);
      in_valid = 1; in_op = op; in_rd = rd; in_rs = rs; in_rt = rt;
      chk("rnd_ready", in_ready, 1);
      rand_pl();
      ex = m[rs]; ey = m[rt];
      tick();
      in_valid = 0; in_op = 4'($urandom); in_rd = 3'($urandom);
      chk("rnd_ctrl", alu_ctrl, op);
      chk("rnd_x", alu_x, ex);
      chk("rnd_y", alu_y, ey);
      chk("rnd_exec_ready", in_ready, 0);
      rand_pl();
      res = alu_fn(op, ex, ey);
      mwrite(rd, res[7:0]);
      mc = res[8];
      tick();
      pl_we = 0;
      chk("rnd_done", done, 1);
      chk("rnd_carry", carry_flag, mc);
      dbg(rd, d);
      chk("rnd_rd", d, m[rd]);
      a = 3'($urandom);
      dbg(a, d);
      chk("rnd_reg", d, m[a]);
      rand_pl();
      tick();
      pl_we = 0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_issue_unit.md
Name: alu_issue_unit

Overview:
- Operand-issue and writeback stage directly upstream of the 8-bit ALU (alu_rtl: ctrl[3:0], x[7:0], y[7:0] -> carry, out[7:0]).
- Holds a small register file and accepts one ALU command per valid/ready handshake.
- Drives the ALU operands and control for one cycle, then writes the ALU result and carry back into the register file.
- Provides a preload write port and a debug read port for bench and system access.

Parameters:
DW, 8, datapath width; must match the ALU width.
AW, 3, register address width; 2**AW registers, r0 hard-wired to zero.
CW, 4, ALU control width.

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  command valid
in_ready  output  1  unit can accept a command this cycle
in_op  input  CW  ALU control code, passed through unmodified
in_rd  input  AW  destination register
in_rs  input  AW  source register for ALU x
in_rt  input  AW  source register for ALU y
alu_ctrl  output  CW  to ALU ctrl
alu_x  output  DW  to ALU x
alu_y  output  DW  to ALU y
alu_carry  input  1  from ALU carry
alu_out  input  DW  from ALU out
carry_flag  output  1  carry captured from the last completed command
done  output  1  one-cycle pulse when a writeback has completed
pl_we  input  1  preload write enable
pl_addr  input  AW  preload address
pl_data  input  DW  preload data
dbg_addr  input  AW  debug read address
dbg_data  output  DW  combinational read of reg[dbg_addr]

Behaviour:
- Clock and reset: one clock (clk), synchronous active-high reset (rst).
- Reset (sampled at a clk edge while rst=1):
  - all registers = 0; state = IDLE; carry_flag = 0; done = 0; latched command fields = 0.
  - rst dominates every other input that cycle, including mid-EXEC or in DONE; the pending command is discarded with no writeback.
- FSM states: IDLE, EXEC, DONE.
  - IDLE: in_ready=1. On in_valid=1, latch op/rd/rs/rt and go to EXEC. Otherwise stay in IDLE.
  - EXEC: in_ready=0. Drive the ALU for exactly one cycle: alu_ctrl=latched op, alu_x=reg[rs], alu_y=reg[rt]. At the closing edge:
    - reg[rd] <= alu_out, unless rd==0;
    - carry_flag <= alu_carry (updated even when rd==0);
    - go to DONE.
  - DONE: in_ready=0, done=1 for this single cycle, then go to IDLE unconditionally.
- Outside EXEC: alu_ctrl, alu_x and alu_y hold their last values, 0 after reset.
- Latency: handshake at edge E0 -> ALU driven in cycle E0..E1 -> result visible in the register file and on dbg_data after E1. done is high in cycle E1..E2. Next accept earliest at E3. Throughput is 1 command / 3 cycles.
- Operand reads in EXEC see the register file as of entering EXEC, plus any preload written at E0.
  - Source equal to destination is legal; the old value is read.
- r0 reads as 0 always. Writes to r0 (writeback or preload) are silently dropped.
- Preload:
  - pl_we=1 writes pl_data to reg[pl_addr] at the edge, in any state.
  - If a preload and a writeback target the same register at the same edge, the writeback wins.
  - A preload at the accept edge E0 to rs/rt is visible to the EXEC read.
- No arithmetic in this block. Data widths pass through as-is; carry is stored verbatim.
- in_valid while in_ready=0 is ignored; there is no queueing, so the source must hold the command.
- X on in_op/in_rd/in_rs/in_rt is don't-care when in_valid=0.

Test Plan:
- Reset: rst=1 for 2 cycles, then deassert. Require in_ready=1, done=0, carry_flag=0, and dbg_data=0 for all 8 addresses.
- NOT via real alu_rtl: preload r1=8'h00, issue op=4'b0100, rd=2, rs=1, rt=0. Require alu_x=8'h00 and alu_ctrl=4'b0100 in EXEC, done pulse exactly 2 cycles after accept, and dbg_data(r2)=8'hFF after it.
- Back-to-back: hold in_valid=1 with two commands. Require the second accepted exactly 3 cycles after the first, and in_ready low for those 2 intermediate cycles.
- r0 protection: issue NOT with rd=0, rs=1 (r1=8'h00), and preload r0=8'h55. Require dbg_data(r0)=8'h00 throughout; carry_flag still updates to the ALU carry.
- Writeback/preload collision: during EXEC of NOT r1->r3 with r1=8'h0F, assert pl_we to r3 with 8'hAA at the closing edge. Require r3=8'hF0.
- Reset mid-operation: accept a command, assert rst during EXEC. Require no writeback to rd, state back in IDLE (in_ready=1 next cycle), and no done pulse.
